audio_capture_fifo: RTL and testbench

//  FPGA-side producer for the HPS audio read path. Deserialises WM8731 ADC I2S data (codec is
//  bit-clock/LRCK master), packs one stereo frame into a 32-bit word and buffers frames in a FIFO.
//  The HPS reads that FIFO through the audio / fifo_empty / fifo_read PIOs.

---
 rtl/audio_capture_fifo.sv | 152 +++++++++++++++
 tb/tb_audio_capture_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_capture_fifo.sv
`timescale 1ns/1ps
// Deserialises WM8731 I2S ADC frames into {L,R} words held in a show-ahead FIFO for the HPS PIOs.
// A word is visible 1 clk after commit. No backpressure to the codec: a frame that finds the FIFO full is dropped and overflow sticks.
module audio_capture_fifo #(
  parameter int SAMPLE_W   = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic                    AUD_BCLK,
  input  logic                    AUD_ADCLRCK,
  input  logic                    AUD_ADCDAT,
  input  logic                    record_en,
  input  logic [9:0]              config_audio,
  input  logic                    fifo_read,
  output logic [2*SAMPLE_W-1:0]   audio_data,
  output logic                    fifo_empty,
  output logic                    overflow,
  output logic [DEPTH_LOG2:0]     fill_level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(SAMPLE_W + 1);
  localparam int WW    = 2 * SAMPLE_W;

  typedef enum logic [2:0] {WAIT_L, SKIP_L, LEFT, WAIT_R, SKIP_R, RIGHT} state_t;

  logic [1:0] bclk_sync, lrck_sync, dat_sync, rd_sync;
  logic       bclk_hist, lrck_hist, rd_hist;
  logic       bclk_rise, lrck, lrck_fall, lrck_rise, rd_pulse;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      rd_sync   <= '0;
      bclk_hist <= 1'b0;
      rd_hist   <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], AUD_BCLK};
      lrck_sync <= {lrck_sync[0], AUD_ADCLRCK};
      dat_sync  <= {dat_sync[0], AUD_ADCDAT};
      rd_sync   <= {rd_sync[0], fifo_read};
      bclk_hist <= bclk_sync[1];
      rd_hist   <= rd_sync[1];
    end
  end

  assign bclk_rise = bclk_sync[1] & ~bclk_hist;
  assign rd_pulse  = rd_sync[1] & ~rd_hist;
  assign lrck      = lrck_sync[1];
  assign lrck_fall = lrck_hist & ~lrck;
  assign lrck_rise = ~lrck_hist & lrck;

  state_t              state;
  logic [SAMPLE_W-2:0] shift_reg;
  logic [SAMPLE_W-1:0] shift_next, left_q;
  logic [CW-1:0]       bit_cnt, cnt_next;
  logic                in_left, wrong_toggle;
  logic                commit_vld;
  logic [WW-1:0]       commit_dat;

  // The rise that reveals the LRCK edge is the I2S delay slot; the SKIP rise carries the MSB.
  assign shift_next   = {shift_reg, dat_sync[1]};
  assign cnt_next     = (state == SKIP_L || state == SKIP_R) ? CW'(1) : bit_cnt + CW'(1);
  assign in_left      = (state == SKIP_L || state == LEFT);
  assign wrong_toggle = in_left ? lrck_rise : lrck_fall;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state      <= WAIT_L;
      shift_reg  <= '0;
      left_q     <= '0;
      bit_cnt    <= '0;
      lrck_hist  <= 1'b0;
      commit_vld <= 1'b0;
      commit_dat <= '0;
    end else begin
      commit_vld <= 1'b0;
      if (bclk_rise) begin
        lrck_hist <= lrck;
        case (state)
          WAIT_L: if (lrck_fall) state <= SKIP_L;
          WAIT_R: if (lrck_rise) state <= SKIP_R;
          default: begin
            if (wrong_toggle) begin
              // Short slot: drop the partial frame and resync on the edge just seen.
              state <= in_left ? WAIT_L : SKIP_L;
            end else begin
              shift_reg <= shift_next[SAMPLE_W-2:0];
              bit_cnt   <= cnt_next;
              if (cnt_next != CW'(SAMPLE_W)) begin
                state <= in_left ? LEFT : RIGHT;
              end else if (in_left) begin
                left_q <= shift_next;
                state  <= WAIT_R;
              end else begin
                commit_vld <= 1'b1;
                commit_dat <= {left_q, config_audio[1] ? left_q : shift_next};
                state      <= WAIT_L;
              end
            end
          end
        endcase
      end
    end
  end

  logic [WW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_ptr_next;
  logic                  flush, full, push_req, push, pop, drop, head_is_new;
  logic                  unused_cfg;

  assign unused_cfg  = ^config_audio[9:2];
  assign flush       = config_audio[0];
  assign full        = fill_level[DEPTH_LOG2];
  assign fifo_empty  = (fill_level == '0);
  assign push_req    = commit_vld & record_en & ~flush;
  assign pop         = rd_pulse & ~fifo_empty & ~flush;
  assign push        = push_req & (~full | pop);
  assign drop        = push_req & full & ~pop;
  assign rd_ptr_next = rd_ptr + DEPTH_LOG2'(pop);
  // The pushed word becomes the head when nothing else remains after this cycle's pop.
  assign head_is_new = push & (fill_level == (DEPTH_LOG2+1)'(pop));

  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= commit_dat;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
      audio_data <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + DEPTH_LOG2'(push);
      rd_ptr     <= rd_ptr_next;
      fill_level <= fill_level + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
      if (drop) overflow <= 1'b1;
      audio_data <= head_is_new ? commit_dat : mem[rd_ptr_next];
    end
  end

endmodule

// File: tb/tb_audio_capture_fifo.sv
`timescale 1ns/1ps
// Bench for audio_capture_fifo: I2S codec BFM with random frames against a queue model of the HPS FIFO.
module tb_audio_capture_fifo;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT;
  logic        record_en;
  logic [9:0]  config_audio;
  logic        fifo_read;
  logic [31:0] audio_data;
  logic        fifo_empty, overflow;
  logic [8:0]  fill_level;

  audio_capture_fifo dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .AUD_BCLK(AUD_BCLK), .AUD_ADCLRCK(AUD_ADCLRCK), .AUD_ADCDAT(AUD_ADCDAT),
    .record_en(record_en), .config_audio(config_audio), .fifo_read(fifo_read),
    .audio_data(audio_data), .fifo_empty(fifo_empty), .overflow(overflow),
    .fill_level(fill_level)
  );

  always #10 clk_clk = ~clk_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: what the HPS should be able to read.
  logic [31:0] mq[$];
  bit          movf    = 1'b0;
  bit          m_rec   = 1'b1;
  bit          m_mono  = 1'b0;
  bit          m_flush = 1'b0;

  bit async_mode = 1'b0;
  int slot_len   = 17;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ":fill"}, 32'(fill_level), 32'(mq.size()));
    check({tag, ":empty"}, 32'(fifo_empty), 32'(mq.size() == 0));
    check({tag, ":ovf"}, 32'(overflow), 32'(movf));
    if (mq.size() > 0) check({tag, ":head"}, audio_data, mq[0]);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk_clk);
  endtask

  // One BCLK period: LRCK and data change with the falling edge, codec-style.
  task automatic bfm_bit(input logic lr, input logic d, input bit rd_hit);
    AUD_BCLK = 1'b0; AUD_ADCLRCK = lr; AUD_ADCDAT = d;
    if (async_mode) begin
      #163; AUD_BCLK = 1'b1; #163;
    end else begin
      repeat (2) @(negedge clk_clk);
      AUD_BCLK = 1'b1;
      @(negedge clk_clk);
      if (rd_hit) fifo_read = 1'b1;
      @(negedge clk_clk);
    end
  endtask

  // Slot: one delay bit, then nbits of s MSB first, then junk up to len bits.
  task automatic send_slot(input logic lr, input logic [15:0] s, input int nbits, input int len, input bit rd_last);
    logic d;
    for (int k = 0; k < len; k++) begin
      d = (k >= 1 && k <= nbits) ? s[4'(16 - k)] : 1'($urandom);
      bfm_bit(lr, d, rd_last && (k == 16));
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit rd_last);
    send_slot(1'b0, l, 16, slot_len, 1'b0);
    send_slot(1'b1, r, 16, slot_len, rd_last);
  endtask

  task automatic model_push(input logic [31:0] w);
    if (!m_flush && m_rec) begin
      if (mq.size() < 256) mq.push_back(w);
      else movf = 1'b1;
    end
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r);
    send_frame(l, r, 1'b0);
    model_push({l, m_mono ? l : r});
  endtask

  task automatic rand_frames(input int n);
    for (int i = 0; i < n; i++) frame(16'($urandom), 16'($urandom));
  endtask

  task automatic do_pop();
    logic [31:0] tmp;
    fifo_read = 1'b1;
    if (!m_flush && mq.size() > 0) tmp = mq.pop_front();
    repeat (10) @(negedge clk_clk);
    fifo_read = 1'b0;
    repeat (10) @(negedge clk_clk);
  endtask

  task automatic drain(input string tag);
    while (mq.size() > 0) do_pop();
    check_state(tag);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] l, r;
    logic [31:0] tmp;
    reset_reset_n = 1'b0;
    AUD_BCLK = 1'b1; AUD_ADCLRCK = 1'b1; AUD_ADCDAT = 1'b0;
    record_en = 1'b1; config_audio = '0; fifo_read = 1'b0;
    repeat (4) @(negedge clk_clk);
    check("rst:data", audio_data, 32'h0);
    check_state("rst");
    reset_reset_n = 1'b1;
    @(negedge clk_clk);

    // 3.072 MHz bit clock, 32-bit slots, asynchronous to clk
    async_mode = 1'b1; slot_len = 32;
    bfm_bit(1'b1, 1'b0, 1'b0);
    bfm_bit(1'b1, 1'b0, 1'b0);
    frame(16'hA5C3, 16'h0F01);
    async_mode = 1'b0; slot_len = 17;
    @(negedge clk_clk);
    settle();
    check("t1:data", audio_data, 32'hA5C30F01);
    check_state("t1");
    do_pop();
    check_state("t1_pop");

    rand_frames(3);
    settle();
    check_state("t2_push");
    for (int i = 0; i < 3; i++) begin
      do_pop();
      check_state("t2_pop");
    end
    check("t2:empty", 32'(fifo_empty), 32'h1);
    do_pop();
    check_state("t2_pop_empty");

    record_en = 1'b0; m_rec = 1'b0;
    rand_frames(5);
    settle();
    check_state("t3_off");
    record_en = 1'b1; m_rec = 1'b1;
    rand_frames(2);
    settle();
    check_state("t3_on");
    drain("t3_drain");

    config_audio[1] = 1'b1; m_mono = 1'b1;
    frame(16'h1234, 16'hFFFF);
    settle();
    check("t6:mono", audio_data, 32'h12341234);
    config_audio[1] = 1'b0; m_mono = 1'b0;
    send_slot(1'b0, 16'($urandom), 16, 17, 1'b0);
    send_slot(1'b1, 16'($urandom), 8, 9, 1'b0);
    rand_frames(1);
    send_slot(1'b0, 16'($urandom), 8, 9, 1'b0);
    send_slot(1'b1, 16'($urandom), 16, 17, 1'b0);
    rand_frames(1);
    settle();
    check_state("t6_short");
    drain("t6_drain");

    rand_frames(1);
    fork
      send_frame(16'($urandom), 16'($urandom), 1'b0);
      begin
        repeat (30) @(negedge clk_clk);
        reset_reset_n = 1'b0;
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
      end
    join
    mq.delete(); movf = 1'b0;
    settle();
    check_state("rst_mid");
    rand_frames(1);
    settle();
    check_state("rst_next");
    drain("rst_drain");

    for (int i = 0; i < 256; i++) begin
      rand_frames(1);
      if (i % 64 == 63) begin
        settle();
        check_state("t4_fill");
      end
    end
    check("t4:full", 32'(fill_level), 32'd256);

    l = 16'($urandom); r = 16'($urandom);
    send_frame(l, r, 1'b1);
    tmp = mq.pop_front();
    mq.push_back({l, r});
    repeat (4) @(negedge clk_clk);
    fifo_read = 1'b0;
    repeat (12) @(negedge clk_clk);
    check_state("t5_pushpop");

    rand_frames(1);
    settle();
    check("t4:ovf", 32'(overflow), 32'h1);
    check_state("t4_drop");

    config_audio[0] = 1'b1; m_flush = 1'b1;
    mq.delete(); movf = 1'b0;
    repeat (3) @(negedge clk_clk);
    check_state("flush");
    rand_frames(1);
    do_pop();
    check_state("flush_blk");
    config_audio[0] = 1'b0; m_flush = 1'b0;
    repeat (2) @(negedge clk_clk);
    rand_frames(2);
    settle();
    check_state("post_flush");
    do_pop();
    check_state("post_flush_pop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
